// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller: opcodes, ALU op
// codes understood by the ALU control decoder, state encoding and control bundle.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_RTYPE  = 3'b000;
   localparam logic [2:0] ALUOP_MEM    = 3'b001;
   localparam logic [2:0] ALUOP_ADD    = 3'b010;
   localparam logic [2:0] ALUOP_AND    = 3'b011;
   localparam logic [2:0] ALUOP_BRANCH = 3'b100;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BEQEX  = 4'd8,
      S_IMMEX  = 4'd9,
      S_IMMWB  = 4'd10,
      S_JEX    = 4'd11
   } state_t;

   localparam state_t RESET_STATE = S_FETCH;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [2:0] alu_op;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational decode of controller state (plus opcode and memory ready) into
// the datapath control bundle. Unlisted controls stay at zero in every state.
module mc_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  op,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            // IR and PC only update on the cycle the instruction word arrives
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.illegal   = !is_legal_op(op);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = ALUOP_MEM;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_RTEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_RTYPE;
         end
         S_RTWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALUOP_BRANCH;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_IMMEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = (op == OP_ANDI) ? ALUOP_AND : ALUOP_ADD;
         end
         S_IMMWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_JEX: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: state register and next-state logic; the
// datapath controls are decoded from the current state by mc_ctrl_decode.
module mc_main_ctrl
   import mips_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  Op,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemtoReg,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSource,
   output logic [2:0]  Aluop,
   output logic        illegal,
   output logic [3:0]  state
);

   state_t state_reg;
   ctrl_t  ctrl;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RESET_STATE;
      end else begin
         case (state_reg)
            S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
            S_DECODE: begin
               case (Op)
                  OP_LW, OP_SW:     state_reg <= S_MEMADR;
                  OP_RTYPE:         state_reg <= S_RTEX;
                  OP_BEQ:           state_reg <= S_BEQEX;
                  OP_ADDI, OP_ANDI: state_reg <= S_IMMEX;
                  OP_J:             state_reg <= S_JEX;
                  default:          state_reg <= S_FETCH;
               endcase
            end
            S_MEMADR: state_reg <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_reg <= S_MEMWB;
            S_MEMWR:  if (mem_ready) state_reg <= S_FETCH;
            S_RTEX:   state_reg <= S_RTWB;
            S_IMMEX:  state_reg <= S_IMMWB;
            default:  state_reg <= S_FETCH;
         endcase
      end
   end

   mc_ctrl_decode u_decode (
      .state     (state_reg),
      .op        (Op),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.i_or_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign PCSource    = ctrl.pc_source;
   assign Aluop       = ctrl.alu_op;
   assign illegal     = ctrl.illegal;
   assign state       = state_reg;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: per-instruction expected cycle sequences built from the
// instruction-level behaviour, driven with random wait states and opcodes.
module tb_mc_main_ctrl;
   import mips_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] Op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] Aluop;
   logic [3:0] state;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   mc_main_ctrl dut (
      .clk(clk), .rst(rst), .Op(Op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .Aluop(Aluop), .illegal(illegal), .state(state)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       mr;
      logic [5:0] op;
      logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
      logic [1:0] srcb, pcs;
      logic [2:0] aop;
      logic       ill;
   } exp_t;

   exp_t exp_q[$];

   function automatic logic known_op(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                        6'b001000, 6'b001100, 6'b000010};
   endfunction

   function automatic exp_t base(input logic [3:0] st, input logic mr, input logic [5:0] op);
      exp_t e;
      e = '0;
      e.st = st; e.mr = mr; e.op = op;
      return e;
   endfunction

   function automatic logic [17:0] obs_vec();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
              RegWrite, ALUSrcA, ALUSrcB, PCSource, Aluop, illegal};
   endfunction

   function automatic logic [17:0] exp_vec(input exp_t e);
      return {e.pcw, e.pcwc, e.iord, e.mrd, e.mwr, e.irw, e.m2r, e.rdst,
              e.rw, e.srca, e.srcb, e.pcs, e.aop, e.ill};
   endfunction

   // Reference: the cycle-by-cycle life of one instruction
   task automatic build(input logic [5:0] op, input int fw, input int mw);
      exp_t e;
      exp_q.delete();
      for (int i = 0; i <= fw; i++) begin
         e = base(S_FETCH, (i == fw), 6'($urandom));
         e.mrd = 1'b1; e.srcb = 2'b01; e.aop = 3'b010;
         e.irw = (i == fw); e.pcw = (i == fw);
         exp_q.push_back(e);
      end
      e = base(S_DECODE, 1'($urandom), op);
      e.srcb = 2'b11; e.aop = 3'b010; e.ill = !known_op(op);
      exp_q.push_back(e);
      if (op == 6'b100011 || op == 6'b101011) begin
         e = base(S_MEMADR, 1'($urandom), op);
         e.srca = 1'b1; e.srcb = 2'b10; e.aop = 3'b001;
         exp_q.push_back(e);
         for (int i = 0; i <= mw; i++) begin
            e = base((op == 6'b100011) ? S_MEMRD : S_MEMWR, (i == mw), op);
            e.iord = 1'b1;
            if (op == 6'b100011) e.mrd = 1'b1; else e.mwr = 1'b1;
            exp_q.push_back(e);
         end
         if (op == 6'b100011) begin
            e = base(S_MEMWB, 1'($urandom), op);
            e.rw = 1'b1; e.m2r = 1'b1;
            exp_q.push_back(e);
         end
      end else if (op == 6'b000000) begin
         e = base(S_RTEX, 1'($urandom), op);
         e.srca = 1'b1; e.aop = 3'b000;
         exp_q.push_back(e);
         e = base(S_RTWB, 1'($urandom), op);
         e.rw = 1'b1; e.rdst = 1'b1;
         exp_q.push_back(e);
      end else if (op == 6'b000100) begin
         e = base(S_BEQEX, 1'($urandom), op);
         e.srca = 1'b1; e.aop = 3'b100; e.pcwc = 1'b1; e.pcs = 2'b01;
         exp_q.push_back(e);
      end else if (op == 6'b001000 || op == 6'b001100) begin
         e = base(S_IMMEX, 1'($urandom), op);
         e.srca = 1'b1; e.srcb = 2'b10; e.aop = (op == 6'b001100) ? 3'b011 : 3'b010;
         exp_q.push_back(e);
         e = base(S_IMMWB, 1'($urandom), op);
         e.rw = 1'b1;
         exp_q.push_back(e);
      end else if (op == 6'b000010) begin
         e = base(S_JEX, 1'($urandom), op);
         e.pcw = 1'b1; e.pcs = 2'b10;
         exp_q.push_back(e);
      end
   endtask

   // Runs one instruction, checking every cycle; returns observed activity counts
   task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw,
                            output int n_cyc, output int n_mwr, output int n_rw,
                            output int n_ill, output int n_we_late);
      exp_t e;
      build(op, fw, mw);
      n_cyc = 0; n_mwr = 0; n_rw = 0; n_ill = 0; n_we_late = 0;
      foreach (exp_q[i]) begin
         e = exp_q[i];
         mem_ready = e.mr;
         Op = e.op;
         @(negedge clk);
         tests_run++;
         if (state !== e.st) begin
            tests_failed++;
            $display("FAIL %s state cyc%0d: got %0d expected %0d", name, i, state, e.st);
         end
         tests_run++;
         if (obs_vec() !== exp_vec(e)) begin
            tests_failed++;
            $display("FAIL %s outputs cyc%0d st%0d: got %h expected %h", name, i, e.st,
                     obs_vec(), exp_vec(e));
         end
         n_cyc++;
         if (MemWrite) n_mwr++;
         if (RegWrite) n_rw++;
         if (illegal) n_ill++;
         if (state != S_FETCH && (PCWrite || PCWriteCond || IRWrite || RegWrite || MemWrite))
            n_we_late++;
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (state !== S_FETCH) begin
         tests_failed++;
         $display("FAIL %s return_to_fetch: got %0d expected %0d", name, state, S_FETCH);
      end
      @(posedge clk); #1;
      $display("[TB] %s op=%b fetch_waits=%0d mem_waits=%0d cycles=%0d", name, op, fw, mw, n_cyc);
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ready = 1'b0; Op = 6'b000000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (state !== S_FETCH || MemRead !== 1'b1 || Aluop !== 3'b010 || illegal !== 1'b0 ||
          ALUSrcB !== 2'b01 || MemWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: got st=%0d rd=%b aop=%b ill=%b srcb=%b wr=%b expected st=0 rd=1 aop=010 ill=0 srcb=01 wr=0",
                  state, MemRead, Aluop, illegal, ALUSrcB, MemWrite);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("[TB] reset from power-up");
   endtask

   task automatic test_reset_mid_memwr();
      mem_ready = 1'b1; Op = 6'b111000;
      @(posedge clk); #1;
      mem_ready = 1'b0; Op = 6'b101011;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      tests_run++;
      if (state !== S_MEMWR || MemWrite !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_mid_memwr pre: got st=%0d wr=%b expected st=%0d wr=1",
                  state, MemWrite, S_MEMWR);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      tests_run++;
      if (state !== S_FETCH || MemWrite !== 1'b0 || MemRead !== 1'b1 || Aluop !== 3'b010 ||
          illegal !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_memwr post: got st=%0d wr=%b rd=%b aop=%b ill=%b expected st=0 wr=0 rd=1 aop=010 ill=0",
                  state, MemWrite, MemRead, Aluop, illegal);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("[TB] reset during MEMWR wait");
   endtask

   task automatic test_lw();
      int c, w, r, il, late;
      run_instr("lw", 6'b100011, 0, 0, c, w, r, il, late);
      tests_run++;
      if (r !== 1) begin
         tests_failed++;
         $display("FAIL lw regwrite_cycles: got %0d expected 1", r);
      end
   endtask

   task automatic test_sw_wait();
      int c, w, r, il, late;
      run_instr("sw_wait3", 6'b101011, 0, 3, c, w, r, il, late);
      tests_run++;
      if (w !== 4 || r !== 0) begin
         tests_failed++;
         $display("FAIL sw memwrite/regwrite cycles: got %0d/%0d expected 4/0", w, r);
      end
   endtask

   task automatic test_alu_ops();
      int c, w, r, il, late;
      run_instr("rtype", 6'b000000, 1, 0, c, w, r, il, late);
      run_instr("addi", 6'b001000, 0, 0, c, w, r, il, late);
      run_instr("andi", 6'b001100, 2, 0, c, w, r, il, late);
   endtask

   task automatic test_branch_jump();
      int c, w, r, il, late;
      run_instr("beq", 6'b000100, 0, 0, c, w, r, il, late);
      run_instr("j", 6'b000010, 0, 0, c, w, r, il, late);
   endtask

   task automatic test_illegal();
      int c, w, r, il, late;
      run_instr("illegal", 6'b111111, 0, 0, c, w, r, il, late);
      tests_run++;
      if (il !== 1 || late !== 0) begin
         tests_failed++;
         $display("FAIL illegal pulse/write_enables: got %0d/%0d expected 1/0", il, late);
      end
   endtask

   task automatic test_random();
      logic [5:0] ops[7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                             6'b001000, 6'b001100, 6'b000010};
      logic [5:0] op;
      int c, w, r, il, late;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) op = 6'($urandom);
         else op = ops[$urandom_range(0, 6)];
         run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3), c, w, r, il, late);
         tests_run++;
         if (il !== (known_op(op) ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL random illegal_count op=%b: got %0d expected %0d", op, il,
                     known_op(op) ? 0 : 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_wait();
      test_alu_ops();
      test_branch_jump();
      test_illegal();
      test_reset_mid_memwr();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
